// File: rtl/ofm_pkg.sv
// Shared types and constants for the OFM write path.
package ofm_pkg;

  localparam int unsigned OFM_DEPTH  = 128;
  localparam int unsigned OFM_LANES  = 4;
  localparam int unsigned OFM_LANE_W = 2;
  localparam int unsigned OFM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DUMP,
    DONE
  } ofm_wr_state_t;

  // A word closes on its last lane or at the end of a row.
  function automatic logic lane_wraps(input logic [OFM_LANE_W-1:0] lane, input logic last);
    return (lane == OFM_LANE_W'(OFM_LANES - 1)) || last;
  endfunction

endpackage

// File: rtl/ofm_write_ctrl_if.sv
// Byte stream in, byte-lane write bus out, plus the image dump request.
interface ofm_write_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  import ofm_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [OFM_DATA_W-1:0] in_data;
  logic                  in_last;
  logic                  write;
  logic [ADDR_W-1:0]     address;
  logic [OFM_LANE_W-1:0] offset;
  logic [OFM_DATA_W-1:0] data;
  logic                  writeOut;

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, write, address, offset, data, writeOut
  );

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, write, address, offset, data, writeOut
  );

endinterface

// File: rtl/ofm_byte_packer.sv
// Lane/word pointer for the OFM: packs bytes MSB lane first, realigns rows,
// and suppresses writes that fall beyond the memory.
module ofm_byte_packer
  import ofm_pkg::*;
#(
  parameter int unsigned DEPTH     = OFM_DEPTH,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  accept_i,
  input  logic [OFM_DATA_W-1:0] data_i,
  input  logic                  last_i,
  output logic                  write_o,
  output logic [ADDR_W-1:0]     address_o,
  output logic [OFM_LANE_W-1:0] offset_o,
  output logic [OFM_DATA_W-1:0] data_o,
  output logic                  overflow_o
);

  // Wide enough that the pointer never wraps back into range within a frame.
  localparam int unsigned PTR_W = ADDR_W + 3;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [OFM_LANE_W-1:0] lane_q, lane_d;
  logic                  write_q, write_d;
  logic [ADDR_W-1:0]     address_q, address_d;
  logic [OFM_LANE_W-1:0] offset_q, offset_d;
  logic [OFM_DATA_W-1:0] data_q, data_d;
  logic                  overflow_q, overflow_d;
  logic                  in_range_c;

  // Pointer and registered write port state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= PTR_W'(BASE_ADDR);
      lane_q     <= '0;
      write_q    <= 1'b0;
      address_q  <= '0;
      offset_q   <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      lane_q     <= lane_d;
      write_q    <= write_d;
      address_q  <= address_d;
      offset_q   <= offset_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  // Place each accepted byte, then advance lane or word.
  always_comb begin
    ptr_d      = ptr_q;
    lane_d     = lane_q;
    write_d    = 1'b0;
    address_d  = address_q;
    offset_d   = offset_q;
    data_d     = data_q;
    overflow_d = overflow_q;
    in_range_c = (ptr_q < PTR_W'(DEPTH));

    if (clear_i) begin
      ptr_d      = PTR_W'(BASE_ADDR);
      lane_d     = '0;
      overflow_d = 1'b0;
    end else if (accept_i) begin
      write_d   = in_range_c;
      address_d = ADDR_W'(ptr_q);
      offset_d  = lane_q;
      data_d    = data_i;
      if (!in_range_c) begin
        overflow_d = 1'b1;
      end
      if (lane_wraps(lane_q, last_i)) begin
        lane_d = '0;
        ptr_d  = ptr_q + PTR_W'(1);
      end else begin
        lane_d = lane_q + OFM_LANE_W'(1);
      end
    end
  end

  assign write_o    = write_q;
  assign address_o  = address_q;
  assign offset_o   = offset_q;
  assign data_o     = data_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/ofm_write_ctrl.sv
// Frame controller feeding the OFM memory: counts bytes of a frame, drives the
// packer, then requests an image dump and reports completion.
module ofm_write_ctrl
  import ofm_pkg::*;
#(
  parameter int unsigned DEPTH     = OFM_DEPTH,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W+1:0] total,
  ofm_write_ctrl_if.slave   bus,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned CNT_W = ADDR_W + 2;

  ofm_wr_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             in_ready_q, in_ready_d;
  logic             write_out_q, write_out_d;
  logic             start_c;
  logic             accept_c;

  assign accept_c = bus.in_valid & in_ready_q;

  // State, byte counter and registered status outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      total_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      write_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      total_q     <= total_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      write_out_q <= write_out_d;
    end
  end

  // Next state; dump and done pulses trail their states so the final write lands first.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    total_d     = total_q;
    busy_d      = busy_q;
    start_c     = 1'b0;
    write_out_d = (state_q == DUMP);
    done_d      = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          start_c = 1'b1;
          total_d = total;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = (total == '0) ? DUMP : RUN;
        end
      end
      RUN: begin
        if (accept_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == total_q) begin
            state_d = DUMP;
          end
        end
      end
      DUMP: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == RUN);
  end

  ofm_byte_packer #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR)
  ) u_packer (
    .clk       (clock),
    .rst_n     (rst_n),
    .clear_i   (start_c),
    .accept_i  (accept_c),
    .data_i    (bus.in_data),
    .last_i    (bus.in_last),
    .write_o   (bus.write),
    .address_o (bus.address),
    .offset_o  (bus.offset),
    .data_o    (bus.data),
    .overflow_o(overflow)
  );

  assign bus.in_ready = in_ready_q;
  assign bus.writeOut = write_out_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_ofm_write_ctrl.sv
// Bench for ofm_write_ctrl: two instances (base 0 and base 126) see the same
// stream; their writes are compared with a row/word placement model.
module tb_ofm_write_ctrl;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TOT_W  = ADDR_W + 2;
  localparam int unsigned DEPTH  = 128;
  localparam int unsigned BASE1  = 126;

  typedef struct packed {
    logic [7:0] a;
    logic [1:0] o;
    logic [7:0] d;
  } wr_t;

  logic             clock = 1'b0;
  logic             rst_n;
  logic             start;
  logic [TOT_W-1:0] total;
  logic             busy0, done0, ovf0, busy1, done1, ovf1;

  int checks = 0;
  int errors = 0;

  logic [7:0] bytes[$];
  bit         lasts[$];
  wr_t        act0[$], act1[$];
  time        wo0[$], wo1[$], dn0[$], dn1[$];

  ofm_write_ctrl_if #(.ADDR_W(ADDR_W)) if0 ();
  ofm_write_ctrl_if #(.ADDR_W(ADDR_W)) if1 ();

  ofm_write_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) u_dut0 (
    .clock(clock), .rst_n(rst_n), .start(start), .total(total), .bus(if0),
    .busy(busy0), .done(done0), .overflow(ovf0)
  );

  ofm_write_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE1)) u_dut1 (
    .clock(clock), .rst_n(rst_n), .start(start), .total(total), .bus(if1),
    .busy(busy1), .done(done1), .overflow(ovf1)
  );

  always #5 clock = ~clock;

  // Record what each memory port sees, mid-cycle.
  always @(negedge clock) begin
    if (if0.write === 1'b1) act0.push_back(wr_t'({if0.address, if0.offset, if0.data}));
    if (if1.write === 1'b1) act1.push_back(wr_t'({if1.address, if1.offset, if1.data}));
    if (if0.writeOut === 1'b1) wo0.push_back($time);
    if (if1.writeOut === 1'b1) wo1.push_back($time);
    if (done0 === 1'b1) dn0.push_back($time);
    if (done1 === 1'b1) dn1.push_back($time);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit l);
    if0.in_valid = v; if0.in_data = d; if0.in_last = l;
    if1.in_valid = v; if1.in_data = d; if1.in_last = l;
  endtask

  task automatic clear_logs();
    act0.delete(); act1.delete(); wo0.delete(); wo1.delete(); dn0.delete(); dn1.delete();
  endtask

  // Word = base + whole words used by earlier rows + position/4; lane = position%4.
  task automatic place(input int unsigned base, input int idx,
                       output int unsigned word, output int unsigned lane);
    int unsigned rw, len;
    rw = base;
    len = 0;
    for (int j = 0; j < idx; j++) begin
      len++;
      if (lasts[j]) begin
        rw += (len + 3) / 4;
        len = 0;
      end
    end
    word = rw + len / 4;
    lane = len % 4;
  endtask

  task automatic compare(input string tag, input wr_t act[$], input wr_t exp[$],
                         input time wo[$], input time dn[$], input time t_last,
                         input logic ovf_obs, input bit ovf_exp);
    chk($sformatf("%s_nwrites", tag), 32'(act.size()), 32'(exp.size()));
    for (int k = 0; k < act.size() && k < exp.size(); k++)
      chk($sformatf("%s_write%0d", tag, k), 32'(act[k]), 32'(exp[k]));
    chk($sformatf("%s_writeout_count", tag), 32'(wo.size()), 32'd1);
    if (wo.size() > 0) chk($sformatf("%s_writeout_time", tag), 32'(wo[0] - t_last), 32'd20);
    chk($sformatf("%s_done_count", tag), 32'(dn.size()), 32'd1);
    if (dn.size() > 0) chk($sformatf("%s_done_time", tag), 32'(dn[0] - t_last), 32'd30);
    chk($sformatf("%s_overflow", tag), 32'(ovf_obs), 32'(ovf_exp));
  endtask

  // One frame of bytes[]/lasts[]; t_last is mid-cycle before the final accepting edge.
  task automatic run_frame(input bit gaps);
    int n, i, budget, w;
    time t_s, t_last;
    bit hs, rdy_bad, eo0, eo1;
    int unsigned wd, ln;
    wr_t e0[$], e1[$];
    n = bytes.size();
    clear_logs();
    total = TOT_W'(n);
    start = 1'b1;
    @(negedge clock);
    t_s = $time;
    @(posedge clock); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy0), 32'd1);
    t_last = t_s;
    i = 0; budget = 0; rdy_bad = 0;
    while (i < n && budget < 400) begin
      if (gaps && $urandom_range(0, 1) == 0) drive(1'b0, 8'h00, 1'b0);
      else drive(1'b1, bytes[i], lasts[i]);
      @(negedge clock);
      if (if0.in_ready !== 1'b1 || if1.in_ready !== 1'b1) rdy_bad = 1;
      hs = (if0.in_valid === 1'b1) && (if0.in_ready === 1'b1);
      if (hs) t_last = $time;
      @(posedge clock); #1;
      if (hs) i++;
      budget++;
    end
    drive(1'b0, 8'h00, 1'b0);
    if (n > 0) chk("ready_held_in_run", 32'(rdy_bad), 32'd0);
    chk("bytes_accepted", 32'(i), 32'(n));
    w = 0;
    while (done0 !== 1'b1 && w < 20) begin
      @(posedge clock); #1;
      w++;
    end
    chk("done_reached", 32'(done0), 32'd1);
    chk("busy_low_at_done", 32'(busy0), 32'd0);
    repeat (2) begin @(posedge clock); #1; end
    chk("done_dropped", 32'(done0), 32'd0);
    eo0 = 0; eo1 = 0;
    for (int k = 0; k < n; k++) begin
      place(0, k, wd, ln);
      if (wd < DEPTH) e0.push_back(wr_t'({8'(wd), 2'(ln), bytes[k]})); else eo0 = 1;
      place(BASE1, k, wd, ln);
      if (wd < DEPTH) e1.push_back(wr_t'({8'(wd), 2'(ln), bytes[k]})); else eo1 = 1;
    end
    compare("base0", act0, e0, wo0, dn0, t_last, ovf0, eo0);
    compare("base126", act1, e1, wo1, dn1, t_last, ovf1, eo1);
  endtask

  task automatic fill_random(input int n, input int last_pct);
    bytes.delete(); lasts.delete();
    for (int k = 0; k < n; k++) begin
      bytes.push_back(8'($urandom));
      lasts.push_back($urandom_range(0, 99) < last_pct);
    end
  endtask

  initial begin
    int i, budget;
    bit hs;
    logic [31:0] word0;
    rst_n = 1'b0; start = 1'b0; total = '0;
    drive(1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_in_ready", 32'(if0.in_ready), 32'd0);
    chk("rst_write", 32'(if0.write), 32'd0);
    chk("rst_writeout", 32'(if0.writeOut), 32'd0);
    chk("rst_address", 32'(if0.address), 32'd0);
    chk("rst_overflow", 32'(ovf1), 32'd0);

    // Dense eight-byte frame: two full words.
    bytes.delete(); lasts.delete();
    for (int k = 1; k <= 8; k++) begin bytes.push_back(8'(k)); lasts.push_back(1'b0); end
    run_frame(1'b0);
    if (act0.size() > 4) chk("t1_word1_lane0", 32'(act0[4]), 32'({8'd1, 2'd0, 8'h05}));

    // Short row closed by in_last on the third byte.
    bytes = '{8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33};
    lasts = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    run_frame(1'b0);
    word0 = 32'h0;
    foreach (act0[k]) if (act0[k].a == 8'd0) word0[31 - 8 * int'(act0[k].o) -: 8] = act0[k].d;
    chk("t2_word0_image", word0, 32'hAABBCC00);

    // Sparse valid.
    fill_random(5, 0);
    run_frame(1'b1);

    // Twelve bytes: the base-126 instance runs off the end of memory.
    fill_random(12, 0);
    run_frame(1'b0);
    chk("t4_overflow_base126", 32'(ovf1), 32'd1);
    chk("t4_no_overflow_base0", 32'(ovf0), 32'd0);

    // Empty frame.
    bytes.delete(); lasts.delete();
    run_frame(1'b0);

    // Reset after three of eight bytes.
    fill_random(8, 0);
    clear_logs();
    total = TOT_W'(8);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    i = 0; budget = 0;
    while (i < 3 && budget < 50) begin
      drive(1'b1, bytes[i], 1'b0);
      @(negedge clock);
      hs = (if0.in_valid === 1'b1) && (if0.in_ready === 1'b1);
      @(posedge clock); #1;
      if (hs) i++;
      budget++;
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("t6_bytes_before_reset", 32'(i), 32'd3);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_write", 32'({if0.write, if1.write}), 32'd0);
    chk("t6_rst_busy", 32'({busy0, busy1}), 32'd0);
    chk("t6_rst_in_ready", 32'({if0.in_ready, if1.in_ready}), 32'd0);
    chk("t6_rst_addr_off_data", 32'({if0.address, if0.offset, if0.data}), 32'd0);
    chk("t6_rst_flags", 32'({if0.writeOut, done0, ovf0, if1.writeOut, done1}), 32'd0);
    clear_logs();
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("t6_no_writeout", 32'(wo0.size() + wo1.size()), 32'd0);
    chk("t6_no_done", 32'(dn0.size() + dn1.size()), 32'd0);
    chk("t6_no_writes", 32'(act0.size() + act1.size()), 32'd0);
    fill_random(8, 0);
    run_frame(1'b0);

    // Random frames with random row ends and gaps.
    for (int f = 0; f < 6; f++) begin
      fill_random(int'($urandom_range(1, 20)), 25);
      run_frame(bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
